// File: rtl/sim_report_arbiter.sv
// Round-robin owner of the sim_report channel with per-checker verdict aggregation
// and a watchdog that forces a final verdict so unattended runs always terminate.

module sim_report_done_flag (
    input  logic refclk,
    input  logic rst,
    input  logic chk_done,
    input  logic chk_pass,
    output logic done_seen,
    output logic pass_seen
);
    // First chk_done wins; the verdict captured with it is never revised.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            done_seen <= 1'b0;
            pass_seen <= 1'b0;
        end else if (chk_done && !done_seen) begin
            done_seen <= 1'b1;
            pass_seen <= chk_pass;
        end
    end
endmodule

module sim_report_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          HOLD_CYCLES    = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic [31:0] IDLE_CODE      = 32'h0000_0000,
    parameter logic [31:0] TIMEOUT_CODE   = 32'hDEAD_0001
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] req_code,
    output logic [NUM_REQ-1:0]    ack,
    input  logic [NUM_REQ-1:0]    chk_done,
    input  logic [NUM_REQ-1:0]    chk_pass,
    output logic [31:0]           sim_report,
    output logic [3:0]            report_owner,
    output logic                  sim_success,
    output logic                  sim_done,
    output logic                  timeout
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = PW + 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HOLD, FINAL} state_t;

    state_t                   state, state_nxt;
    logic [PW-1:0]            rr, rr_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [31:0]              wd, wd_nxt;
    logic [NUM_REQ-1:0]       done_seen, pass_seen;
    logic [NUM_REQ-1:0][31:0] codes;
    logic [NUM_REQ-1:0]       ack_nxt;
    logic [31:0]              report_nxt;
    logic [3:0]               owner_nxt;
    logic                     success_nxt, done_nxt, timeout_nxt;
    logic                     found, arb_slot, complete, expire;
    logic [PW-1:0]            gidx, scan;
    logic [SW-1:0]            sum, nxt_rr;

    assign codes = req_code;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
        sim_report_done_flag u_flag (
            .refclk    (refclk),
            .rst       (rst),
            .chk_done  (chk_done[i]),
            .chk_pass  (chk_pass[i]),
            .done_seen (done_seen[i]),
            .pass_seen (pass_seen[i])
        );
    end

    // Scan downward so the last hit is the nearest set bit at or after rr.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        scan  = '0;
        sum   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            sum = {1'b0, rr} + SW'(j);
            if (sum >= SW'(NUM_REQ))
                sum = sum - SW'(NUM_REQ);
            scan = sum[PW-1:0];
            if (req[scan]) begin
                found = 1'b1;
                gidx  = scan;
            end
        end
        nxt_rr = {1'b0, gidx} + SW'(1);
        if (nxt_rr == SW'(NUM_REQ))
            nxt_rr = '0;
    end

    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr;
        cnt_nxt     = cnt;
        wd_nxt      = wd;
        ack_nxt     = '0;
        report_nxt  = sim_report;
        owner_nxt   = report_owner;
        success_nxt = sim_success;
        done_nxt    = sim_done;
        timeout_nxt = timeout;

        arb_slot = (state == IDLE) || (state == HOLD && cnt == '0);
        complete = arb_slot && !found && (&done_seen);
        expire   = (TIMEOUT_CYCLES != 32'd0) && (state != FINAL) &&
                   (wd == TIMEOUT_CYCLES - 32'd1);

        if (state != FINAL && wd != '1)
            wd_nxt = wd + 32'd1;

        // Completion outranks the watchdog; the watchdog outranks a grant.
        if (complete) begin
            state_nxt   = FINAL;
            done_nxt    = 1'b1;
            success_nxt = &pass_seen;
        end else if (expire) begin
            state_nxt   = FINAL;
            timeout_nxt = 1'b1;
            done_nxt    = 1'b1;
            success_nxt = 1'b0;
            report_nxt  = TIMEOUT_CODE;
        end else if (arb_slot) begin
            if (found) begin
                state_nxt     = HOLD;
                report_nxt    = codes[gidx];
                owner_nxt     = 4'(gidx);
                ack_nxt[gidx] = 1'b1;
                rr_nxt        = nxt_rr[PW-1:0];
                cnt_nxt       = CW'(HOLD_CYCLES - 1);
            end else begin
                state_nxt = IDLE;
            end
        end else if (state == HOLD) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state        <= IDLE;
            rr           <= '0;
            cnt          <= '0;
            wd           <= '0;
            ack          <= '0;
            sim_report   <= IDLE_CODE;
            report_owner <= '0;
            sim_success  <= 1'b0;
            sim_done     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr           <= rr_nxt;
            cnt          <= cnt_nxt;
            wd           <= wd_nxt;
            ack          <= ack_nxt;
            sim_report   <= report_nxt;
            report_owner <= owner_nxt;
            sim_success  <= success_nxt;
            sim_done     <= done_nxt;
            timeout      <= timeout_nxt;
        end
    end
endmodule

// File: tb/tb_sim_report_arbiter.sv
// Bench for sim_report_arbiter: vector table, directed corner sequences, and
// randomized traffic checked against a timestamp-based reference model.

module tb_sim_report_arbiter;
    localparam int          N      = 4;
    localparam int          H      = 16;
    localparam int          T      = 200;
    localparam logic [31:0] IDLE_C = 32'h0000_0000;
    localparam logic [31:0] TO_C   = 32'hDEAD_0001;

    logic            refclk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, ack, chk_done, chk_pass;
    logic [N*32-1:0] req_code;
    logic [31:0]     sim_report;
    logic [3:0]      report_owner;
    logic            sim_success, sim_done, timeout;

    always #5 refclk = ~refclk;

    sim_report_arbiter #(
        .NUM_REQ        (N),
        .HOLD_CYCLES    (H),
        .TIMEOUT_CYCLES (32'd200),
        .IDLE_CODE      (IDLE_C),
        .TIMEOUT_CODE   (TO_C)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .req          (req),
        .req_code     (req_code),
        .ack          (ack),
        .chk_done     (chk_done),
        .chk_pass     (chk_pass),
        .sim_report   (sim_report),
        .report_owner (report_owner),
        .sim_success  (sim_success),
        .sim_done     (sim_done),
        .timeout      (timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference model: arbitration allowed whenever the edge index reaches the
    // timestamp of the next permitted grant; watchdog fires at edge T after reset.
    logic [31:0] m_rep;
    logic [3:0]  m_owner;
    logic [N-1:0] m_ack;
    logic        m_succ, m_done, m_to;
    int          m_rr, m_t, m_next;
    bit          m_final;
    bit          m_dseen[N];
    bit          m_pseen[N];

    task automatic model_edge();
        bit all_done, all_pass;
        int w;
        if (!rst) begin
            m_rep = IDLE_C; m_owner = '0; m_ack = '0;
            m_succ = 1'b0; m_done = 1'b0; m_to = 1'b0;
            m_rr = 0; m_t = 0; m_next = 0; m_final = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_dseen[i] = 1'b0;
                m_pseen[i] = 1'b0;
            end
            return;
        end
        m_t++;
        m_ack = '0;
        if (!m_final) begin
            all_done = 1'b1;
            all_pass = 1'b1;
            for (int i = 0; i < N; i++) begin
                all_done &= m_dseen[i];
                all_pass &= m_pseen[i];
            end
            w = -1;
            if (m_t >= m_next)
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
            if (m_t >= m_next && req == '0 && all_done) begin
                m_final = 1'b1; m_done = 1'b1; m_succ = all_pass;
            end else if (m_t == T) begin
                m_final = 1'b1; m_to = 1'b1; m_done = 1'b1; m_succ = 1'b0; m_rep = TO_C;
            end else if (w >= 0) begin
                m_rep = req_code[32*w +: 32];
                m_owner = w[3:0];
                m_ack[w] = 1'b1;
                m_rr = (w + 1) % N;
                m_next = m_t + H;
            end
        end
        for (int i = 0; i < N; i++)
            if (chk_done[i] && !m_dseen[i]) begin
                m_dseen[i] = 1'b1;
                m_pseen[i] = chk_pass[i];
            end
    endtask

    task automatic tick();
        model_edge();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; chk_done = '0; chk_pass = '0;
        tick();
        rst = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ack"},     ack,          m_ack);
        check({tag, ".report"},  sim_report,   m_rep);
        check({tag, ".owner"},   report_owner, m_owner);
        check({tag, ".done"},    sim_done,     m_done);
        check({tag, ".success"}, sim_success,  m_succ);
        check({tag, ".timeout"}, timeout,      m_to);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  ack;
        logic [31:0] rep;
        logic [3:0]  owner;
        logic        done;
    } vec_t;

    vec_t vt[9];

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, want finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int e, rate;
        bit hit;
        logic [3:0] exp_ack;

        req_code = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        rst = 1'b0; req = '0; chk_done = '0; chk_pass = '0;

        // reset with requests pending, single grant, reset mid-hold, rr restart at 0
        vt[0] = '{1'b0, 4'hF,    4'h0,    32'h0,         4'd0, 1'b0};
        vt[1] = '{1'b0, 4'hF,    4'h0,    32'h0,         4'd0, 1'b0};
        vt[2] = '{1'b0, 4'hF,    4'h0,    32'h0,         4'd0, 1'b0};
        vt[3] = '{1'b1, 4'b0100, 4'b0100, 32'hA5A5_0002, 4'd2, 1'b0};
        vt[4] = '{1'b1, 4'b0000, 4'h0,    32'hA5A5_0002, 4'd2, 1'b0};
        vt[5] = '{1'b1, 4'b0001, 4'h0,    32'hA5A5_0002, 4'd2, 1'b0};
        vt[6] = '{1'b0, 4'b0001, 4'h0,    32'h0,         4'd0, 1'b0};
        vt[7] = '{1'b1, 4'b1001, 4'b0001, 32'hA5A5_0000, 4'd0, 1'b0};
        vt[8] = '{1'b1, 4'b0000, 4'h0,    32'hA5A5_0000, 4'd0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rst = vt[i].rst;
            req = vt[i].req;
            tick();
            check($sformatf("vec%0d.ack", i),     ack,          vt[i].ack);
            check($sformatf("vec%0d.report", i),  sim_report,   vt[i].rep);
            check($sformatf("vec%0d.owner", i),   report_owner, vt[i].owner);
            check($sformatf("vec%0d.done", i),    sim_done,     vt[i].done);
            check($sformatf("vec%0d.success", i), sim_success,  1'b0);
            check($sformatf("vec%0d.timeout", i), timeout,      1'b0);
        end

        // next grant after a single request lands exactly HOLD edges later
        do_reset();
        req = 4'b0100;
        tick();
        check("single.ack", ack, 4'b0100);
        check("single.report", sim_report, 32'hA5A5_0002);
        req = 4'b0010;
        e = 1; hit = 1'b0;
        while (e < 40 && !hit) begin
            tick();
            e++;
            if (ack != '0) hit = 1'b1;
        end
        check("single.spacing", e, 1 + H);
        check("single.owner", report_owner, 4'd1);
        req = '0;

        // round-robin with all requests held high
        do_reset();
        req = 4'hF;
        for (int c = 1; c <= 70; c++) begin
            tick();
            exp_ack = ((c - 1) % H == 0) ? 4'(1 << (((c - 1) / H) % N)) : 4'h0;
            check($sformatf("rr.ack@%0d", c), ack, exp_ack);
            if (exp_ack != 0) begin
                check($sformatf("rr.owner@%0d", c), report_owner, ((c - 1) / H) % N);
                check($sformatf("rr.report@%0d", c), sim_report, 32'hA5A5_0000 + ((c - 1) / H) % N);
            end
        end

        // verdict with a failing checker, then frozen under requests
        do_reset();
        chk_pass = 4'b1011; chk_done = 4'hF;
        tick();
        check("verdict.done_early", sim_done, 1'b0);
        chk_done = '0; chk_pass = 4'hF;
        tick();
        check("verdict.done", sim_done, 1'b1);
        check("verdict.success", sim_success, 1'b0);
        check("verdict.timeout", timeout, 1'b0);
        req = 4'hF;
        repeat (5) tick();
        check("verdict.frozen_ack", ack, 4'h0);
        check("verdict.frozen_report", sim_report, IDLE_C);
        check("verdict.frozen_done", sim_done, 1'b1);
        check("verdict.frozen_success", sim_success, 1'b0);

        do_reset();
        chk_pass = 4'hF; chk_done = 4'hF;
        tick();
        chk_done = '0; chk_pass = '0;
        tick();
        check("verdict_pass.done", sim_done, 1'b1);
        check("verdict_pass.success", sim_success, 1'b1);

        // watchdog preempts a hold in progress
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= T - 1; c++) tick();
        check("wd.timeout_before", timeout, 1'b0);
        check("wd.done_before", sim_done, 1'b0);
        tick();
        check("wd.timeout", timeout, 1'b1);
        check("wd.done", sim_done, 1'b1);
        check("wd.success", sim_success, 1'b0);
        check("wd.report", sim_report, TO_C);
        check("wd.ack", ack, 4'h0);
        req = 4'hF;
        repeat (3) tick();
        check("wd.frozen_report", sim_report, TO_C);
        check("wd.frozen_ack", ack, 4'h0);

        // completion and watchdog on the same edge: completion wins
        do_reset();
        for (int c = 1; c <= T - 2; c++) tick();
        chk_done = 4'hF; chk_pass = 4'hF;
        tick();
        check("wd_tie.done_early", sim_done, 1'b0);
        chk_done = '0;
        tick();
        check("wd_tie.timeout", timeout, 1'b0);
        check("wd_tie.done", sim_done, 1'b1);
        check("wd_tie.success", sim_success, 1'b1);
        check("wd_tie.report", sim_report, IDLE_C);

        // randomized traffic against the model
        for (int ep = 0; ep < 6; ep++) begin
            rate = $urandom_range(2, 12);
            do_reset();
            for (int c = 0; c < 260; c++) begin
                rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
                tick();
                check_all($sformatf("rand%0d", ep));
                for (int i = 0; i < N; i++) begin
                    if (m_ack[i]) req[i] = 1'b0;
                    else if (!req[i] && $urandom_range(1, rate) == 1) begin
                        req_code[32*i +: 32] = $urandom;
                        req[i] = 1'b1;
                    end
                    chk_done[i] = ($urandom_range(0, 99) < 4);
                    chk_pass[i] = ($urandom_range(0, 7) != 0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
